// File: rtl/proc_issue_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface : proc_issue_arbiter_if
// Brief     : Requester and processor-side signals of proc_issue_arbiter.
//             slave  = arbiter view, master = requester/processor view.
// Revision  : 1.0  initial release
// ============================================================================
interface proc_issue_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IW   = 16
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*IW-1:0] req_instr;
  logic [NREQ-1:0]    ack;
  logic [IW-1:0]      proc_instr;
  logic               run_n;
  logic               proc_done;
  logic               busy;
  logic [GW-1:0]      grant_id;
  logic               timeout;

  modport slave (
    input  req, req_instr, proc_done,
    output ack, proc_instr, run_n, busy, grant_id, timeout
  );

  modport master (
    output req, req_instr, proc_done,
    input  ack, proc_instr, run_n, busy, grant_id, timeout
  );
endinterface
`default_nettype wire

// File: rtl/proc_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : proc_issue_arbiter
// Brief    : Round-robin issue scheduler sharing one processor control
//            unit among NREQ requesters (IDLE -> ISSUE -> WAIT -> ACK).
// Options  : define ARB_TIMEOUT_EN to abandon a WAIT after TO_CYCLES cycles
//            without proc_done (timeout pulse, no ack).
// Revision : 1.0  initial release
// ============================================================================
module proc_issue_arbiter #(
  parameter int NREQ      = 4,
  parameter int IW        = 16,
  parameter int TO_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  proc_issue_arbiter_if.slave  bus
);

  localparam int              GW      = $clog2(NREQ);
  localparam logic [GW-1:0]   LAST_ID = GW'(NREQ - 1);
  localparam logic [GW:0]     NREQ_W  = (GW + 1)'(NREQ);

  if (NREQ < 2 || NREQ > 8 || TO_CYCLES < 1) begin : g_param_check
    $error("proc_issue_arbiter: NREQ must be 2..8 and TO_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_rr_ptr;
  logic [GW-1:0]   r_grant;
  logic [NREQ-1:0] r_ack;
  logic [IW-1:0]   r_instr;
  logic            r_run_n;
  logic            r_busy;

  logic            w_found;
  logic [GW-1:0]   w_pick;
  logic [GW:0]     w_sum;
  logic [IW-1:0]   w_instr;
  logic [GW-1:0]   w_next_ptr;

  // Search rr_ptr, rr_ptr+1, ... with explicit modulo-NREQ wrap; first hit wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (GW + 1)'(k);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      if (!w_found && bus.req[w_sum[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_sum[GW-1:0];
      end
    end
  end

  // Select the instruction slot belonging to the winning requester.
  always_comb begin
    w_instr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick == GW'(i)) w_instr = bus.req_instr[i*IW +: IW];
    end
  end

  // Pointer to the requester after the current grant, wrapping for any NREQ.
  assign w_next_ptr = (r_grant == LAST_ID) ? '0 : r_grant + 1'b1;

`ifdef ARB_TIMEOUT_EN
  localparam int          CW     = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_timeout;
`endif

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_grant  <= '0;
      r_ack    <= '0;
      r_instr  <= '0;
      r_run_n  <= 1'b1;
      r_busy   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_ack <= '0;
`ifdef ARB_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_instr <= w_instr;
            r_run_n <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_run_n <= 1'b1;
          r_state <= WAIT;
`ifdef ARB_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        WAIT: begin
          // proc_done has priority over a timeout expiring in the same cycle.
          if (bus.proc_done) begin
            r_ack   <= {{(NREQ-1){1'b0}}, 1'b1} << r_grant;
            r_state <= ACK;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_wait_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_busy    <= 1'b0;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        ACK: begin
          r_rr_ptr <= w_next_ptr;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.ack        = r_ack;
  assign bus.proc_instr = r_instr;
  assign bus.run_n      = r_run_n;
  assign bus.busy       = r_busy;
  assign bus.grant_id   = r_grant;
`ifdef ARB_TIMEOUT_EN
  assign bus.timeout    = r_timeout;
`else
  assign bus.timeout    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_proc_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_issue_arbiter
// Brief    : Directed self-checking bench for proc_issue_arbiter (NREQ=4 and
//            NREQ=3 instances). Timeout scenario built when ARB_TIMEOUT_EN.
// Revision : 1.0  initial release
// ============================================================================
module tb_proc_issue_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  proc_issue_arbiter_if #(.NREQ(4), .IW(16)) if4 ();
  proc_issue_arbiter_if #(.NREQ(3), .IW(16)) if3 ();

  proc_issue_arbiter #(.NREQ(4), .IW(16), .TO_CYCLES(16)) dut4 (
    .clk(clk), .reset_n(reset_n), .bus(if4.slave));
  proc_issue_arbiter #(.NREQ(3), .IW(16), .TO_CYCLES(16)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(if3.slave));

  // Advance one cycle and sample 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    if4.req = '0; if4.proc_done = 1'b0;
    if3.req = '0; if3.proc_done = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
  endtask

  // Run one transaction on the 4-way DUT; returns observations only.
  task automatic do_txn4(input int lat, output int id, output logic [15:0] instr,
                         output logic [3:0] ackv, output int gap);
    int n = 0;
    while (if4.run_n !== 1'b0 && n < 20) begin step(); n++; end
    gap = n; id = int'(if4.grant_id); instr = if4.proc_instr; ackv = '0;
    if (n < 20) begin
      repeat (lat) step();
      if4.proc_done = 1'b1; step(); if4.proc_done = 1'b0;
      ackv = if4.ack;
    end
  endtask

  // Same for the 3-way DUT.
  task automatic do_txn3(input int lat, output int id, output logic [2:0] ackv,
                         output int gap);
    int n = 0;
    while (if3.run_n !== 1'b0 && n < 20) begin step(); n++; end
    gap = n; id = int'(if3.grant_id); ackv = '0;
    if (n < 20) begin
      repeat (lat) step();
      if3.proc_done = 1'b1; step(); if3.proc_done = 1'b0;
      ackv = if3.ack;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) step();
    n_tests++; if (if4.ack !== 4'b0)      begin n_fail++; $display("FAIL reset_ack: got %b want 0000", if4.ack); end
    n_tests++; if (if4.run_n !== 1'b1)    begin n_fail++; $display("FAIL reset_run_n: got %b want 1", if4.run_n); end
    n_tests++; if (if4.proc_instr !== 16'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 0000", if4.proc_instr); end
    n_tests++; if (if4.busy !== 1'b0)     begin n_fail++; $display("FAIL reset_busy: got %b want 0", if4.busy); end
    n_tests++; if (if4.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", if4.grant_id); end
    n_tests++; if (if4.timeout !== 1'b0)  begin n_fail++; $display("FAIL reset_timeout: got %b want 0", if4.timeout); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    int n = 0;
    if4.req_instr = {16'h4004, 16'h2A05, 16'h2002, 16'h1001};
    if4.req = 4'b0100;
    while (if4.run_n !== 1'b0 && n < 10) begin step(); n++; end
    n_tests++; if (n !== 1)                  begin n_fail++; $display("FAIL single_issue_latency: got %0d want 1", n); end
    n_tests++; if (if4.proc_instr !== 16'h2A05) begin n_fail++; $display("FAIL single_instr: got %h want 2a05", if4.proc_instr); end
    n_tests++; if (if4.grant_id !== 2'd2)    begin n_fail++; $display("FAIL single_grant: got %0d want 2", if4.grant_id); end
    n_tests++; if (if4.busy !== 1'b1)        begin n_fail++; $display("FAIL single_busy: got %b want 1", if4.busy); end
    step();
    n_tests++; if (if4.run_n !== 1'b1)       begin n_fail++; $display("FAIL single_run_width: got %b want 1", if4.run_n); end
    step(); step();
    n_tests++; if (if4.proc_instr !== 16'h2A05 || if4.ack !== 4'b0) begin n_fail++; $display("FAIL single_wait_hold: got instr %h ack %b want 2a05 0000", if4.proc_instr, if4.ack); end
    if4.proc_done = 1'b1; step(); if4.proc_done = 1'b0;
    n_tests++; if (if4.ack !== 4'b0100)      begin n_fail++; $display("FAIL single_ack: got %b want 0100", if4.ack); end
    if4.req = 4'b0;
    step();
    n_tests++; if (if4.ack !== 4'b0 || if4.busy !== 1'b0) begin n_fail++; $display("FAIL single_end: got ack %b busy %b want 0000 0", if4.ack, if4.busy); end
  endtask

  task automatic test_round_robin();
    int id, gap;
    logic [15:0] instr;
    logic [3:0]  ackv;
    int          exp_id[5]    = '{0, 1, 2, 3, 0};
    logic [15:0] exp_instr[4] = '{16'hA000, 16'hB001, 16'hC002, 16'hD003};
    apply_reset();
    if4.req_instr = {16'hD003, 16'hC002, 16'hB001, 16'hA000};
    if4.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      do_txn4(2, id, instr, ackv, gap);
      n_tests++; if (id !== exp_id[t]) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", t, id, exp_id[t]); end
      n_tests++; if (instr !== exp_instr[exp_id[t]]) begin n_fail++; $display("FAIL rr_instr[%0d]: got %h want %h", t, instr, exp_instr[exp_id[t]]); end
      n_tests++; if (ackv !== (4'b0001 << exp_id[t])) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", t, ackv, 4'b0001 << exp_id[t]); end
      if (t > 0) begin
        n_tests++; if (gap !== 2) begin n_fail++; $display("FAIL back_to_back_gap[%0d]: got %0d want 2", t, gap); end
      end
    end
    if4.req = 4'b0;
    step(); step();
  endtask

  task automatic test_wrap_nreq3();
    int id, gap;
    logic [2:0] ackv;
    if3.req_instr = {16'h3302, 16'h3301, 16'h3300};
    if3.req = 3'b010;
    do_txn3(1, id, ackv, gap);
    n_tests++; if (id !== 1) begin n_fail++; $display("FAIL wrap_setup_grant: got %0d want 1", id); end
    if3.req = 3'b101;
    do_txn3(1, id, ackv, gap);
    n_tests++; if (id !== 2 || ackv !== 3'b100) begin n_fail++; $display("FAIL wrap_grant2: got id %0d ack %b want 2 100", id, ackv); end
    if3.req = 3'b001;
    do_txn3(1, id, ackv, gap);
    n_tests++; if (id !== 0 || ackv !== 3'b001) begin n_fail++; $display("FAIL wrap_grant0: got id %0d ack %b want 0 001", id, ackv); end
    if3.req = 3'b111;
    do_txn3(1, id, ackv, gap);
    n_tests++; if (id !== 1) begin n_fail++; $display("FAIL wrap_ptr_after: got %0d want 1", id); end
    if3.req = 3'b000;
    step(); step();
  endtask

  task automatic test_drop_and_stray();
    int n = 0;
    if4.proc_done = 1'b1;
    repeat (3) step();
    n_tests++; if (if4.busy !== 1'b0 || if4.run_n !== 1'b1 || if4.ack !== 4'b0) begin n_fail++; $display("FAIL stray_done_idle: got busy %b run_n %b ack %b want 0 1 0000", if4.busy, if4.run_n, if4.ack); end
    if4.proc_done = 1'b0;
    if4.req = 4'b0010;
    while (if4.run_n !== 1'b0 && n < 10) begin step(); n++; end
    n_tests++; if (if4.grant_id !== 2'd1) begin n_fail++; $display("FAIL drop_grant: got %0d want 1", if4.grant_id); end
    step();
    if4.req = 4'b1000;
    step(); step();
    n_tests++; if (if4.busy !== 1'b1 || if4.ack !== 4'b0) begin n_fail++; $display("FAIL drop_no_cancel: got busy %b ack %b want 1 0000", if4.busy, if4.ack); end
    if4.proc_done = 1'b1; step(); if4.proc_done = 1'b0;
    n_tests++; if (if4.ack !== 4'b0010) begin n_fail++; $display("FAIL drop_ack: got %b want 0010", if4.ack); end
    n = 0;
    while (if4.run_n !== 1'b0 && n < 10) begin step(); n++; end
    n_tests++; if (n !== 2 || if4.grant_id !== 2'd3) begin n_fail++; $display("FAIL late_req_grant: got gap %0d id %0d want 2 3", n, if4.grant_id); end
    if4.proc_done = 1'b1; step(); if4.proc_done = 1'b0;
    step();
    n_tests++; if (if4.ack !== 4'b0 || if4.busy !== 1'b1) begin n_fail++; $display("FAIL done_in_issue: got ack %b busy %b want 0000 1", if4.ack, if4.busy); end
    if4.proc_done = 1'b1; step(); if4.proc_done = 1'b0;
    n_tests++; if (if4.ack !== 4'b1000) begin n_fail++; $display("FAIL late_req_ack: got %b want 1000", if4.ack); end
    if4.req = 4'b0;
    step();
  endtask

  task automatic test_reset_mid();
    int id, gap, n;
    logic [15:0] instr;
    logic [3:0]  ackv;
    if4.req = 4'b0010;
    do_txn4(1, id, instr, ackv, gap);
    if4.req = 4'b0100;
    n = 0;
    while (if4.run_n !== 1'b0 && n < 10) begin step(); n++; end
    step(); step();
    #3 reset_n = 1'b0;
    #1;
    n_tests++; if (if4.run_n !== 1'b1 || if4.busy !== 1'b0 || if4.grant_id !== 2'd0 || if4.proc_instr !== 16'h0 || if4.ack !== 4'b0)
      begin n_fail++; $display("FAIL reset_async: got run_n %b busy %b id %0d instr %h ack %b want 1 0 0 0000 0000", if4.run_n, if4.busy, if4.grant_id, if4.proc_instr, if4.ack); end
    if4.proc_done = 1'b1;
    step(); step();
    n_tests++; if (if4.ack !== 4'b0) begin n_fail++; $display("FAIL reset_no_ack: got %b want 0000", if4.ack); end
    if4.proc_done = 1'b0;
    if4.req = 4'b1111;
    reset_n = 1'b1;
    do_txn4(1, id, instr, ackv, gap);
    n_tests++; if (id !== 0 || ackv !== 4'b0001) begin n_fail++; $display("FAIL reset_restart: got id %0d ack %b want 0 0001", id, ackv); end
    if4.req = 4'b0;
    step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n = 0;
    if4.req = 4'b0110;
    while (if4.run_n !== 1'b0 && n < 10) begin step(); n++; end
    n_tests++; if (if4.grant_id !== 2'd1) begin n_fail++; $display("FAIL to_grant: got %0d want 1", if4.grant_id); end
    repeat (16) step();
    n_tests++; if (if4.timeout !== 1'b0 || if4.busy !== 1'b1) begin n_fail++; $display("FAIL to_early: got timeout %b busy %b want 0 1", if4.timeout, if4.busy); end
    step();
    n_tests++; if (if4.timeout !== 1'b1 || if4.ack !== 4'b0 || if4.busy !== 1'b0) begin n_fail++; $display("FAIL to_pulse: got timeout %b ack %b busy %b want 1 0000 0", if4.timeout, if4.ack, if4.busy); end
    step();
    n_tests++; if (if4.timeout !== 1'b0 || if4.run_n !== 1'b0 || if4.grant_id !== 2'd2) begin n_fail++; $display("FAIL to_next: got timeout %b run_n %b id %0d want 0 0 2", if4.timeout, if4.run_n, if4.grant_id); end
    if4.req = 4'b0100;
    step();
    if4.proc_done = 1'b1; step(); if4.proc_done = 1'b0;
    n_tests++; if (if4.ack !== 4'b0100) begin n_fail++; $display("FAIL to_next_ack: got %b want 0100", if4.ack); end
    if4.req = 4'b0;
    step();
  endtask
`else
  task automatic test_wait_hold();
    int n = 0;
    int seen_to = 0;
    if4.req = 4'b0001;
    while (if4.run_n !== 1'b0 && n < 10) begin step(); n++; end
    for (int c = 0; c < 40; c++) begin
      step();
      if (if4.timeout !== 1'b0) seen_to++;
    end
    n_tests++; if (seen_to !== 0) begin n_fail++; $display("FAIL hold_timeout: got %0d pulses want 0", seen_to); end
    n_tests++; if (if4.busy !== 1'b1 || if4.ack !== 4'b0 || if4.proc_instr !== 16'hA000) begin n_fail++; $display("FAIL hold_wait: got busy %b ack %b instr %h want 1 0000 a000", if4.busy, if4.ack, if4.proc_instr); end
    if4.proc_done = 1'b1; step(); if4.proc_done = 1'b0;
    n_tests++; if (if4.ack !== 4'b0001) begin n_fail++; $display("FAIL hold_ack: got %b want 0001", if4.ack); end
    if4.req = 4'b0;
    step();
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    if4.req = '0; if4.req_instr = '0; if4.proc_done = 1'b0;
    if3.req = '0; if3.req_instr = '0; if3.proc_done = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_nreq3();
    test_drop_and_stray();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`else
    test_wait_hold();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
